jesd204_frame_align_monitor: RTL and testbench
==============================================

// Module: jesd204_frame_align_monitor
// PURPOSE
// - RX-side checker for /F/ (K28.7, 0xFC) and /A/ (K28.3, 0x7C) alignment characters after 8b10b decode.
// - Sits in the lane path after descrambler bypass and before character replacement.
// - Compares each alignment character against local frame/multiframe marks (eof/eomf).
// - Counts misplaced characters; after ERR_THRESHOLD consecutive bad beats, requests lane realignment via handshake.
// PARAMETERS
// - DATA_PATH_WIDTH  4   octets per beat; legal 4, 8
// - ERR_THRESHOLD    4   consecutive bad beats that trigger realign_req; 1..15
// - CNT_WIDTH        16  width of saturating status counters
// PORTS
// - clk                   in   1          lane clock
// - resetn                in   1          asynchronous, active-low reset
// - cfg_octets_per_frame  in   8          F-1
// - cfg_disable_scrambler in   1          1 = scrambler off
// - cfg_disable_char_replacement in 1     1 = no alignment characters on link
// - in_valid              in   1          beat qualifier
// - in_data               in   DPW*8      decoded octets; octet i = [8i+:8]
// - in_charisk            in   DPW        per-octet K flag
// - in_eof                in   DPW        per-octet end-of-frame mark
// - in_eomf               in   DPW        per-octet end-of-multiframe mark
// - clear_cnt             in   1          synchronous clear of all status counters
// - realign_ack           in   1          acknowledges realign_req
// - align_err             out  1          1-cycle pulse per bad beat
// - realign_req           out  1          level; held until acknowledged
// - status_aligned        out  1          1 = no unresolved misalignment
// - status_align_err_cnt  out  CNT_WIDTH  bad-beat count, saturating
// BEHAVIOUR
// - Monitor active when cfg_disable_scrambler=1 and cfg_disable_char_replacement=0.
// - Per-octet classification (in_valid=1 only):
//   - good: A with eomf=1, or F with eof=1 and eomf=0
//   - bad:  A with eomf=0, F with eof=0, or F with eomf=1
//   - Other K values and data octets are ignored.
// - Stage 1: per-octet good/bad flags registered at edge N+1 (beat in cycle N).
// - Stage 2, edge N+2:
//   - beat_bad = |bad
//   - beat_good = |good && !beat_bad
//   - FSM, align_err, and counters update together.
// - FSM states:
//   - DISABLED: status_aligned=1; on active, go to MONITOR next edge.
//   - MONITOR: status_aligned=1. On beat_bad: consec=1, then REALIGN if ERR_THRESHOLD=1, else MISALIGNED.
//   - MISALIGNED: status_aligned=0.
//     - beat_bad: consec+1; go to REALIGN when consec reaches ERR_THRESHOLD.
//     - beat_good: consec=0, go to MONITOR.
//     - Neither: hold.
//   - REALIGN: realign_req=1, status_aligned=0. Beats do not move the FSM. realign_ack=1 sampled: consec=0, go to MONITOR; realign_req drops next cycle.
// - Monitor goes inactive in any state: DISABLED at next edge, stage-1 flags flushed, realign_req=0, counters hold.
// - Counters: +1 per beat_bad, saturate at all-ones. clear_cnt wins over a same-cycle increment (result 0).
// - align_err pulses on every beat_bad, including in REALIGN.
// - Reset (asynchronous, also mid-operation): state DISABLED, consec=0, stage-1 flags 0. Outputs reset to align_err=0, realign_req=0, status_aligned=0, status_align_err_cnt=0.
// CONFIGURATION
// - Macro JESD204_FRAME_ALIGN_STATS_EN.
// - Defined: adds outputs status_a_cnt and status_f_cnt (CNT_WIDTH each).
//   - Each counts good A / good F octets, incremented by popcount per beat.
//   - Saturating; cleared by clear_cnt; reset 0.
// - Undefined: ports and logic absent; all other behaviour identical.
// TESTING
// - DPW=4, cfg_octets_per_frame=1, scrambler off, eof=4'b1010, charisk=4'b0010, octet1=0xFC: align_err stays 0, err_cnt=0, status_aligned=1.
// - Same, but 0xFC at octet0 (charisk=4'b0001): align_err=1 for one cycle at edge N+2, err_cnt=1, status_aligned=0.
// - ERR_THRESHOLD=4, 4 consecutive bad beats: realign_req=1 after 4th, held 10 cycles without ack; realign_ack -> realign_req=0 next cycle, status_aligned=1.
// - 3 bad beats then A at eomf octet: back to MONITOR, realign_req never 1, err_cnt=3.
// - cfg_disable_scrambler 1->0 while MISALIGNED: DISABLED next edge, realign_req=0, err_cnt held.
// - err_cnt=0xFFFF plus bad beat: stays 0xFFFF; clear_cnt with bad beat: 0; resetn low in REALIGN: realign_req=0 immediately.

Source files
------------

// File: rtl/jesd204_frame_align_monitor.sv
// RX lane checker for /F/ and /A/ alignment characters against local frame/multiframe marks.
// Optional good-character statistics counters are enabled with JESD204_FRAME_ALIGN_STATS_EN.
module jesd204_frame_align_monitor #(
  parameter int unsigned DATA_PATH_WIDTH = 4,
  parameter int unsigned ERR_THRESHOLD   = 4,
  parameter int unsigned CNT_WIDTH       = 16
) (
  input  logic                         clk,
  input  logic                         resetn,
  input  logic [7:0]                   cfg_octets_per_frame,
  input  logic                         cfg_disable_scrambler,
  input  logic                         cfg_disable_char_replacement,
  input  logic                         in_valid,
  input  logic [DATA_PATH_WIDTH*8-1:0] in_data,
  input  logic [DATA_PATH_WIDTH-1:0]   in_charisk,
  input  logic [DATA_PATH_WIDTH-1:0]   in_eof,
  input  logic [DATA_PATH_WIDTH-1:0]   in_eomf,
  input  logic                         clear_cnt,
  input  logic                         realign_ack,
  output logic                         align_err,
  output logic                         realign_req,
  output logic                         status_aligned,
  output logic [CNT_WIDTH-1:0]         status_align_err_cnt
`ifdef JESD204_FRAME_ALIGN_STATS_EN
  ,
  output logic [CNT_WIDTH-1:0]         status_a_cnt,
  output logic [CNT_WIDTH-1:0]         status_f_cnt
`endif
);

  localparam int unsigned DPW      = DATA_PATH_WIDTH;
  localparam int unsigned CONSEC_W = 4;
  localparam logic [CONSEC_W-1:0] THRESH = CONSEC_W'(ERR_THRESHOLD);
  localparam logic [7:0] CHAR_F = 8'hFC;
  localparam logic [7:0] CHAR_A = 8'h7C;

  typedef enum logic [1:0] {
    ST_DISABLED,
    ST_MONITOR,
    ST_MISALIGNED,
    ST_REALIGN
  } state_e;

  // Frame size does not affect placement checks; marks arrive pre-computed.
  logic [7:0] unused_cfg;
  assign unused_cfg = cfg_octets_per_frame;

  logic active_c;
  assign active_c = cfg_disable_scrambler & ~cfg_disable_char_replacement;

  logic [DPW-1:0] is_a_c, is_f_c;
  for (genvar i = 0; i < DPW; i++) begin : g_cls
    assign is_a_c[i] = in_valid & in_charisk[i] & (in_data[8*i +: 8] == CHAR_A);
    assign is_f_c[i] = in_valid & in_charisk[i] & (in_data[8*i +: 8] == CHAR_F);
  end

  logic [DPW-1:0] a_good_c, f_good_c, bad_c;
  assign a_good_c = is_a_c & in_eomf;
  assign f_good_c = is_f_c & in_eof & ~in_eomf;
  assign bad_c    = (is_a_c & ~in_eomf) | (is_f_c & (~in_eof | in_eomf));

  logic [DPW-1:0] a_good_q, f_good_q, bad_q;

  // Stage 1: per-octet flags, flushed while the monitor is inactive.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      a_good_q <= '0;
      f_good_q <= '0;
      bad_q    <= '0;
    end else if (!active_c) begin
      a_good_q <= '0;
      f_good_q <= '0;
      bad_q    <= '0;
    end else begin
      a_good_q <= a_good_c;
      f_good_q <= f_good_c;
      bad_q    <= bad_c;
    end
  end

  state_e                state_q, state_d;
  logic [CONSEC_W-1:0]   consec_q, consec_d;
  logic                  align_err_q, align_err_d;
  logic                  realign_req_q, realign_req_d;
  logic                  status_aligned_q, status_aligned_d;
  logic [CNT_WIDTH-1:0]  err_cnt_q, err_cnt_d;
  logic                  beat_bad_c, beat_good_c;

  always_comb begin
    state_d          = state_q;
    consec_d         = consec_q;
    err_cnt_d        = err_cnt_q;
    beat_bad_c       = active_c & (|bad_q);
    beat_good_c      = active_c & (|(a_good_q | f_good_q)) & ~(|bad_q);

    if (!active_c) begin
      state_d  = ST_DISABLED;
      consec_d = '0;
    end else begin
      case (state_q)
        ST_DISABLED: state_d = ST_MONITOR;
        ST_MONITOR: begin
          if (beat_bad_c) begin
            consec_d = CONSEC_W'(1);
            state_d  = (THRESH == CONSEC_W'(1)) ? ST_REALIGN : ST_MISALIGNED;
          end
        end
        ST_MISALIGNED: begin
          if (beat_bad_c) begin
            consec_d = consec_q + CONSEC_W'(1);
            if (consec_d >= THRESH) state_d = ST_REALIGN;
          end else if (beat_good_c) begin
            consec_d = '0;
            state_d  = ST_MONITOR;
          end
        end
        ST_REALIGN: begin
          if (realign_ack) begin
            consec_d = '0;
            state_d  = ST_MONITOR;
          end
        end
        default: state_d = ST_DISABLED;
      endcase
    end

    align_err_d      = beat_bad_c;
    realign_req_d    = (state_d == ST_REALIGN);
    status_aligned_d = (state_d == ST_DISABLED) || (state_d == ST_MONITOR);

    // Clear dominates a same-cycle increment; the count saturates at all-ones.
    if (clear_cnt) begin
      err_cnt_d = '0;
    end else if (beat_bad_c && !(&err_cnt_q)) begin
      err_cnt_d = err_cnt_q + CNT_WIDTH'(1);
    end
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q          <= ST_DISABLED;
      consec_q         <= '0;
      align_err_q      <= 1'b0;
      realign_req_q    <= 1'b0;
      status_aligned_q <= 1'b0;
      err_cnt_q        <= '0;
    end else begin
      state_q          <= state_d;
      consec_q         <= consec_d;
      align_err_q      <= align_err_d;
      realign_req_q    <= realign_req_d;
      status_aligned_q <= status_aligned_d;
      err_cnt_q        <= err_cnt_d;
    end
  end

  assign align_err            = align_err_q;
  assign realign_req          = realign_req_q;
  assign status_aligned       = status_aligned_q;
  assign status_align_err_cnt = err_cnt_q;

`ifdef JESD204_FRAME_ALIGN_STATS_EN
  localparam int unsigned POP_W = $clog2(DPW + 1);

  function automatic logic [POP_W-1:0] popcnt(input logic [DPW-1:0] v);
    logic [POP_W-1:0] p;
    p = '0;
    for (int unsigned i = 0; i < DPW; i++) p = p + POP_W'(v[i]);
    return p;
  endfunction

  function automatic logic [CNT_WIDTH-1:0] sat_add(input logic [CNT_WIDTH-1:0] c,
                                                   input logic [POP_W-1:0] inc);
    logic [CNT_WIDTH:0] s;
    s = {1'b0, c} + (CNT_WIDTH+1)'(inc);
    return s[CNT_WIDTH] ? '1 : s[CNT_WIDTH-1:0];
  endfunction

  logic [CNT_WIDTH-1:0] a_cnt_q, a_cnt_d, f_cnt_q, f_cnt_d;

  always_comb begin
    a_cnt_d = a_cnt_q;
    f_cnt_d = f_cnt_q;
    if (clear_cnt) begin
      a_cnt_d = '0;
      f_cnt_d = '0;
    end else if (active_c) begin
      a_cnt_d = sat_add(a_cnt_q, popcnt(a_good_q));
      f_cnt_d = sat_add(f_cnt_q, popcnt(f_good_q));
    end
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      a_cnt_q <= '0;
      f_cnt_q <= '0;
    end else begin
      a_cnt_q <= a_cnt_d;
      f_cnt_q <= f_cnt_d;
    end
  end

  assign status_a_cnt = a_cnt_q;
  assign status_f_cnt = f_cnt_q;
`endif

endmodule

// File: tb/tb_jesd204_frame_align_monitor.sv
// Self-checking bench for jesd204_frame_align_monitor: vector table through a latency scoreboard,
// plus hand-written realign, recovery, disable, saturation and reset sequences.
module tb_jesd204_frame_align_monitor;

  localparam int unsigned DPW = 4;
  localparam int unsigned CW  = 16;

  logic           clk = 1'b0;
  logic           resetn;
  logic [7:0]     cfg_octets_per_frame;
  logic           cfg_disable_scrambler;
  logic           cfg_disable_char_replacement;
  logic           in_valid;
  logic [DPW*8-1:0] in_data;
  logic [DPW-1:0] in_charisk, in_eof, in_eomf;
  logic           clear_cnt, realign_ack;
  logic           align_err, realign_req, status_aligned;
  logic [CW-1:0]  status_align_err_cnt;

  jesd204_frame_align_monitor #(
    .DATA_PATH_WIDTH(DPW), .ERR_THRESHOLD(4), .CNT_WIDTH(CW)
  ) dut (
    .clk(clk), .resetn(resetn),
    .cfg_octets_per_frame(cfg_octets_per_frame),
    .cfg_disable_scrambler(cfg_disable_scrambler),
    .cfg_disable_char_replacement(cfg_disable_char_replacement),
    .in_valid(in_valid), .in_data(in_data), .in_charisk(in_charisk),
    .in_eof(in_eof), .in_eomf(in_eomf),
    .clear_cnt(clear_cnt), .realign_ack(realign_ack),
    .align_err(align_err), .realign_req(realign_req),
    .status_aligned(status_aligned), .status_align_err_cnt(status_align_err_cnt)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        vld;
    logic [31:0] data;
    logic [3:0]  k, eof, eomf;
    logic        ae, req, al;
    logic [15:0] cnt;
  } vec_t;

  typedef struct {
    int          due;
    int          tag;
    logic        ae, req, al;
    logic [15:0] cnt;
  } exp_t;

  vec_t tbl [12];
  exp_t sbq [$];
  int   cyc   = 0;
  int   total = 0;
  int   bad   = 0;

  task automatic chk(input string nm, input int tag, input logic [15:0] got, input logic [15:0] want);
    total++;
    if (got !== want) begin
      bad++;
      $display("FAIL %s tag=%0d cyc=%0d: got %0h want %0h", nm, tag, cyc, got, want);
    end
  endtask

  task automatic chk_all(input int tag, input logic ae, input logic req, input logic al, input logic [15:0] cnt);
    chk("align_err", tag, 16'(align_err), 16'(ae));
    chk("realign_req", tag, 16'(realign_req), 16'(req));
    chk("status_aligned", tag, 16'(status_aligned), 16'(al));
    chk("err_cnt", tag, status_align_err_cnt, cnt);
  endtask

  task automatic expect_out(input int lat, input int tag, input logic ae, input logic req,
                            input logic al, input logic [15:0] cnt);
    exp_t e;
    e.due = cyc + lat; e.tag = tag; e.ae = ae; e.req = req; e.al = al; e.cnt = cnt;
    sbq.push_back(e);
  endtask

  task automatic tick();
    exp_t e;
    @(posedge clk);
    #1;
    cyc++;
    while (sbq.size() > 0 && sbq[0].due <= cyc) begin
      e = sbq.pop_front();
      chk_all(e.tag, e.ae, e.req, e.al, e.cnt);
    end
  endtask

  task automatic beat(input logic vld, input logic [31:0] d, input logic [3:0] k,
                      input logic [3:0] eof, input logic [3:0] eomf);
    in_valid = vld; in_data = d; in_charisk = k; in_eof = eof; in_eomf = eomf;
  endtask

  task automatic idle();
    beat(1'b0, 32'h0, 4'h0, 4'h0, 4'h0);
  endtask

  task automatic bad_f();
    beat(1'b1, 32'h0000_00FC, 4'b0001, 4'b1010, 4'b0000);
  endtask

  task automatic good_a();
    beat(1'b1, 32'h7C00_0000, 4'b1000, 4'b1010, 4'b1000);
  endtask

  initial begin
    tbl[0]  = '{1'b1, 32'h0000_FC00, 4'b0010, 4'b1010, 4'b0000, 1'b0, 1'b0, 1'b1, 16'd0};
    tbl[1]  = '{1'b1, 32'h0000_00FC, 4'b0001, 4'b1010, 4'b0000, 1'b1, 1'b0, 1'b0, 16'd1};
    tbl[2]  = '{1'b0, 32'h0000_00FC, 4'b0001, 4'b1010, 4'b0000, 1'b0, 1'b0, 1'b0, 16'd1};
    tbl[3]  = '{1'b1, 32'h7C00_0000, 4'b1000, 4'b1010, 4'b1000, 1'b0, 1'b0, 1'b1, 16'd1};
    tbl[4]  = '{1'b1, 32'h007C_0000, 4'b0100, 4'b1010, 4'b0000, 1'b1, 1'b0, 1'b0, 16'd2};
    tbl[5]  = '{1'b1, 32'hFC00_0000, 4'b1000, 4'b1000, 4'b1000, 1'b1, 1'b0, 1'b0, 16'd3};
    tbl[6]  = '{1'b1, 32'hFCFC_FCFC, 4'b0000, 4'b0000, 4'b0000, 1'b0, 1'b0, 1'b0, 16'd3};
    tbl[7]  = '{1'b1, 32'h0000_00BC, 4'b0001, 4'b0000, 4'b0000, 1'b0, 1'b0, 1'b0, 16'd3};
    tbl[8]  = '{1'b1, 32'h0000_FCFC, 4'b0011, 4'b1010, 4'b0000, 1'b1, 1'b0, 1'b0, 16'd4};
    tbl[9]  = '{1'b1, 32'h0000_00FC, 4'b0001, 4'b1010, 4'b0000, 1'b1, 1'b1, 1'b0, 16'd5};
    tbl[10] = '{1'b1, 32'h0000_00FC, 4'b0001, 4'b1010, 4'b0000, 1'b1, 1'b1, 1'b0, 16'd6};
    tbl[11] = '{1'b1, 32'h7C00_0000, 4'b1000, 4'b1010, 4'b1000, 1'b0, 1'b1, 1'b0, 16'd6};

    resetn = 1'b0;
    cfg_octets_per_frame = 8'd1;
    cfg_disable_scrambler = 1'b1;
    cfg_disable_char_replacement = 1'b0;
    clear_cnt = 1'b0;
    realign_ack = 1'b0;
    idle();
    #12;
    chk_all(-1, 1'b0, 1'b0, 1'b0, 16'd0);
    @(posedge clk);
    #1;
    resetn = 1'b1;
    expect_out(1, -2, 1'b0, 1'b0, 1'b1, 16'd0);
    tick();
    tick();

    // Table vectors, results due two edges after each beat.
    for (int i = 0; i < 12; i++) begin
      beat(tbl[i].vld, tbl[i].data, tbl[i].k, tbl[i].eof, tbl[i].eomf);
      expect_out(2, i, tbl[i].ae, tbl[i].req, tbl[i].al, tbl[i].cnt);
      tick();
    end
    idle();
    tick();
    tick();

    // Request is held without acknowledge, then drops one edge after ack.
    for (int i = 0; i < 10; i++) begin
      expect_out(1, 100 + i, 1'b0, 1'b1, 1'b0, 16'd6);
      tick();
    end
    realign_ack = 1'b1;
    expect_out(1, 200, 1'b0, 1'b0, 1'b1, 16'd6);
    tick();
    realign_ack = 1'b0;

    // Three bad beats then a good /A/ returns to aligned without a request.
    clear_cnt = 1'b1;
    expect_out(1, 300, 1'b0, 1'b0, 1'b1, 16'd0);
    tick();
    clear_cnt = 1'b0;
    bad_f();  expect_out(2, 301, 1'b1, 1'b0, 1'b0, 16'd1); tick();
    bad_f();  expect_out(2, 302, 1'b1, 1'b0, 1'b0, 16'd2); tick();
    bad_f();  expect_out(2, 303, 1'b1, 1'b0, 1'b0, 16'd3); tick();
    good_a(); expect_out(2, 304, 1'b0, 1'b0, 1'b1, 16'd3); tick();
    idle();   expect_out(2, 305, 1'b0, 1'b0, 1'b1, 16'd3); tick();
    tick();

    // Disabling the monitor while misaligned drops in-flight beats and holds counts.
    bad_f();  expect_out(2, 400, 1'b1, 1'b0, 1'b0, 16'd4); tick();
    idle();   tick();
    tick();
    bad_f();  tick();
    idle();
    cfg_disable_scrambler = 1'b0;
    expect_out(1, 401, 1'b0, 1'b0, 1'b1, 16'd4);
    tick();
    bad_f();  expect_out(1, 402, 1'b0, 1'b0, 1'b1, 16'd4); tick();
    idle();   expect_out(1, 403, 1'b0, 1'b0, 1'b1, 16'd4); tick();
    cfg_disable_scrambler = 1'b1;
    tick();
    bad_f();  expect_out(2, 404, 1'b1, 1'b0, 1'b0, 16'd5); tick();
    idle();   tick();
    tick();

    // Saturation at all-ones, then clear beating a same-cycle increment.
    clear_cnt = 1'b1;
    tick();
    clear_cnt = 1'b0;
    bad_f();
    for (int n = 0; n < 65536; n++) tick();
    chk("sat_reach", 500, status_align_err_cnt, 16'hFFFF);
    tick();
    chk("sat_hold", 501, status_align_err_cnt, 16'hFFFF);
    chk("sat_err_pulse", 502, 16'(align_err), 16'd1);
    clear_cnt = 1'b1;
    tick();
    clear_cnt = 1'b0;
    chk("clear_wins", 503, status_align_err_cnt, 16'd0);
    tick();
    chk("after_clear", 504, status_align_err_cnt, 16'd1);
    chk("in_realign", 505, 16'(realign_req), 16'd1);

    // Asynchronous reset in REALIGN clears outputs without a clock edge.
    @(posedge clk);
    #3;
    resetn = 1'b0;
    #1;
    chk_all(600, 1'b0, 1'b0, 1'b0, 16'd0);
    idle();
    @(negedge clk);
    resetn = 1'b1;
    expect_out(1, 601, 1'b0, 1'b0, 1'b1, 16'd0);
    tick();
    tick();

    if (sbq.size() != 0) begin
      bad++;
      total++;
      $display("FAIL scoreboard_drain: got %0d entries want 0", sbq.size());
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
